// File: rtl/hilo_writeback.sv
// HI/LO writeback buffer: queues ALU split results in order and retires them into HI/LO on commit.
// Optional youngest-pending forwarding to rd_hi/rd_lo is enabled by defining HILO_FORWARD_EN.
module hilo_writeback #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               res_high,
  input  logic [WIDTH-1:0]               res_low,
  input  logic                           wr_hi,
  input  logic                           wr_lo,
  input  logic                           commit,
  input  logic                           flush,
  output logic [WIDTH-1:0]               hi_q,
  output logic [WIDTH-1:0]               lo_q,
  output logic [WIDTH-1:0]               rd_hi,
  output logic [WIDTH-1:0]               rd_lo,
  output logic [$clog2(DEPTH+1)-1:0]     pending,
  output logic                           empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] entryHigh [DEPTH];
  logic [WIDTH-1:0] entryLow  [DEPTH];
  logic             entryWrHi [DEPTH];
  logic             entryWrLo [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign empty    = (count == '0);
  assign pending  = count;
  assign in_ready = !flush && (count < CNT_W'(DEPTH));
  assign doPush   = in_valid && in_ready;
  assign doPop    = commit && !empty && !flush;

  // Entry payload carries no reset; only occupancy decides what is meaningful.
  always_ff @(posedge clock) begin
    if (doPush) begin
      entryHigh[wrPtr] <= res_high;
      entryLow[wrPtr]  <= res_low;
      entryWrHi[wrPtr] <= wr_hi;
      entryWrLo[wrPtr] <= wr_lo;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        if (entryWrHi[rdPtr]) begin
          hi_q <= entryHigh[rdPtr];
        end
        if (entryWrLo[rdPtr]) begin
          lo_q <= entryLow[rdPtr];
        end
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef HILO_FORWARD_EN
  logic [DEPTH-1:0] entryValid;

  // An entry is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gValid
    logic [PTR_W-1:0] age;
    assign age            = PTR_W'(gi) - rdPtr;
    assign entryValid[gi] = CNT_W'(age) < count;
  end

  // Walk from oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    rd_hi = hi_q;
    rd_lo = lo_q;
    idx   = rdPtr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PTR_W'(k);
      if (entryValid[idx] && entryWrHi[idx]) begin
        rd_hi = entryHigh[idx];
      end
      if (entryValid[idx] && entryWrLo[idx]) begin
        rd_lo = entryLow[idx];
      end
    end
  end
`else
  assign rd_hi = hi_q;
  assign rd_lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_writeback.sv
// Scoreboard bench for hilo_writeback: stimulus queues expected state, a negedge monitor pops and compares.
module tb_hilo_writeback;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] res_high;
  logic [31:0] res_low;
  logic        wr_hi;
  logic        wr_lo;
  logic        commit;
  logic        flush;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] rd_hi;
  logic [31:0] rd_lo;
  logic [1:0]  pending;
  logic        empty;

  always #5 clock = ~clock;

  hilo_writeback #(.WIDTH(32), .DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .res_high(res_high), .res_low(res_low), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .commit(commit), .flush(flush), .hi_q(hi_q), .lo_q(lo_q),
    .rd_hi(rd_hi), .rd_lo(rd_lo), .pending(pending), .empty(empty)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdHi;
    logic [31:0] rdLo;
    logic [1:0]  pend;
    logic        rdy;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  // Monitor: each expectation describes the DUT as seen mid-cycle, after that cycle's inputs settle.
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      testsRun++;
      if (hi_q !== e.hi || lo_q !== e.lo || rd_hi !== e.rdHi || rd_lo !== e.rdLo ||
          pending !== e.pend || in_ready !== e.rdy || empty !== (e.pend == 2'd0)) begin
        testsFailed++;
        $display("FAIL %s: got hi=%h lo=%h rd_hi=%h rd_lo=%h pend=%0d rdy=%b empty=%b; want hi=%h lo=%h rd_hi=%h rd_lo=%h pend=%0d rdy=%b empty=%b",
                 e.name, hi_q, lo_q, rd_hi, rd_lo, pending, in_ready, empty,
                 e.hi, e.lo, e.rdHi, e.rdLo, e.pend, e.rdy, (e.pend == 2'd0));
      end else begin
        $display("[TB] %s: hi=%h lo=%h rd_hi=%h rd_lo=%h pend=%0d rdy=%b ok",
                 e.name, hi_q, lo_q, rd_hi, rd_lo, pending, in_ready);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected before this cycle's edge.
  // fHi/fLo are the forwarded read values; without forwarding rd follows hi_q/lo_q.
  task automatic cyc(input string nm, input logic rst, input logic v,
                     input logic [31:0] rh, input logic [31:0] rl,
                     input logic wh, input logic wl, input logic cm, input logic fl,
                     input logic [31:0] eHi, input logic [31:0] eLo,
                     input logic [1:0] ePend, input logic eRdy,
                     input logic [31:0] fHi, input logic [31:0] fLo);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n  = rst;
    in_valid = v;
    res_high = rh;
    res_low  = rl;
    wr_hi    = wh;
    wr_lo    = wl;
    commit   = cm;
    flush    = fl;
    e.name = nm;
    e.hi   = eHi;
    e.lo   = eLo;
    e.pend = ePend;
    e.rdy  = eRdy;
`ifdef HILO_FORWARD_EN
    e.rdHi = fHi;
    e.rdLo = fLo;
`else
    e.rdHi = eHi;
    e.rdLo = eLo;
`endif
    expQ.push_back(e);
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    res_high = '0;
    res_low  = '0;
    wr_hi    = 1'b0;
    wr_lo    = 1'b0;
    commit   = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clock);

    //   name                  rst v  high          low           wh wl cm fl  hi_q       lo_q          pd rdy fwdHi      fwdLo
    cyc("reset_state",          1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h0,     32'h0,        0, 1,  32'h0,     32'h0);
    cyc("push_lo_a5",           1, 1, 32'h0,        32'hA5A5A5A5, 0, 1, 0, 0,  32'h0,     32'h0,        0, 1,  32'h0,     32'h0);
    cyc("commit_lo_a5",         1, 0, 32'h0,        32'h0,        0, 0, 1, 0,  32'h0,     32'h0,        1, 1,  32'h0,     32'hA5A5A5A5);
    cyc("after_commit_lo",      1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h0,     32'hA5A5A5A5, 0, 1,  32'h0,     32'hA5A5A5A5);
    cyc("push_11_22",           1, 1, 32'h11,       32'h22,       1, 1, 0, 0,  32'h0,     32'hA5A5A5A5, 0, 1,  32'h0,     32'hA5A5A5A5);
    cyc("push_33_44",           1, 1, 32'h33,       32'h44,       1, 1, 0, 0,  32'h0,     32'hA5A5A5A5, 1, 1,  32'h11,    32'h22);
    cyc("full_reject_55",       1, 1, 32'h55,       32'h66,       1, 1, 0, 0,  32'h0,     32'hA5A5A5A5, 2, 0,  32'h33,    32'h44);
    cyc("full_commit_no_ready", 1, 1, 32'h77,       32'h88,       1, 1, 1, 0,  32'h0,     32'hA5A5A5A5, 2, 0,  32'h33,    32'h44);
    cyc("commit_second",        1, 0, 32'h0,        32'h0,        0, 0, 1, 0,  32'h11,    32'h22,       1, 1,  32'h33,    32'h44);
    cyc("after_two_commits",    1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h33,    32'h44,       0, 1,  32'h33,    32'h44);
    cyc("stream_prime",         1, 1, 32'hA0,       32'hB0,       1, 1, 0, 0,  32'h33,    32'h44,       0, 1,  32'h33,    32'h44);
    cyc("stream_1",             1, 1, 32'h1,        32'h11,       1, 1, 1, 0,  32'h33,    32'h44,       1, 1,  32'hA0,    32'hB0);
    cyc("stream_2",             1, 1, 32'h2,        32'h12,       1, 1, 1, 0,  32'hA0,    32'hB0,       1, 1,  32'h1,     32'h11);
    cyc("stream_3",             1, 1, 32'h3,        32'h13,       1, 1, 1, 0,  32'h1,     32'h11,       1, 1,  32'h2,     32'h12);
    cyc("stream_4",             1, 1, 32'h4,        32'h14,       1, 1, 1, 0,  32'h2,     32'h12,       1, 1,  32'h3,     32'h13);
    cyc("push_5_fill",          1, 1, 32'h5,        32'h15,       1, 1, 0, 0,  32'h3,     32'h13,       1, 1,  32'h4,     32'h14);
    cyc("flush_full",           1, 1, 32'hEE,       32'hFF,       1, 1, 1, 1,  32'h3,     32'h13,       2, 0,  32'h5,     32'h15);
    cyc("after_flush",          1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h3,     32'h13,       0, 1,  32'h3,     32'h13);
    cyc("commit_while_empty",   1, 0, 32'h0,        32'h0,        0, 0, 1, 0,  32'h3,     32'h13,       0, 1,  32'h3,     32'h13);
    cyc("after_empty_commit",   1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h3,     32'h13,       0, 1,  32'h3,     32'h13);
    cyc("push_hi5",             1, 1, 32'h5,        32'h0,        1, 0, 0, 0,  32'h3,     32'h13,       0, 1,  32'h3,     32'h13);
    cyc("commit_hi5",           1, 0, 32'h0,        32'h0,        0, 0, 1, 0,  32'h3,     32'h13,       1, 1,  32'h5,     32'h13);
    cyc("push_hi9",             1, 1, 32'h9,        32'h0,        1, 0, 0, 0,  32'h5,     32'h13,       0, 1,  32'h5,     32'h13);
    cyc("hi9_pending_read",     1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h5,     32'h13,       1, 1,  32'h9,     32'h13);
    cyc("commit_hi9",           1, 0, 32'h0,        32'h0,        0, 0, 1, 0,  32'h5,     32'h13,       1, 1,  32'h9,     32'h13);
    cyc("after_commit_hi9",     1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h9,     32'h13,       0, 1,  32'h9,     32'h13);
    cyc("push_nowrite",         1, 1, 32'hDEAD,     32'hBEEF,     0, 0, 0, 0,  32'h9,     32'h13,       0, 1,  32'h9,     32'h13);
    cyc("commit_nowrite",       1, 0, 32'h0,        32'h0,        0, 0, 1, 0,  32'h9,     32'h13,       1, 1,  32'h9,     32'h13);
    cyc("after_nowrite",        1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h9,     32'h13,       0, 1,  32'h9,     32'h13);
    cyc("push_21_22",           1, 1, 32'h21,       32'h22,       1, 1, 0, 0,  32'h9,     32'h13,       0, 1,  32'h9,     32'h13);
    cyc("push_23_24",           1, 1, 32'h23,       32'h24,       1, 1, 0, 0,  32'h9,     32'h13,       1, 1,  32'h21,    32'h22);
    cyc("two_pending",          1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h9,     32'h13,       2, 0,  32'h23,    32'h24);
    cyc("async_reset_midrun",   0, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h0,     32'h0,        0, 1,  32'h0,     32'h0);
    cyc("reset_release",        1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h0,     32'h0,        0, 1,  32'h0,     32'h0);
    cyc("post_reset_idle",      1, 0, 32'h0,        32'h0,        0, 0, 0, 0,  32'h0,     32'h0,        0, 1,  32'h0,     32'h0);

    repeat (3) @(negedge clock);
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
